// File: rtl/dice_game_pkg.sv
// Shared definitions for the dice race: colour codes, FSM state encoding, colour-to-steps map.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable; nothing here carries flow control.
package dice_game_pkg;

    // Colour codes produced by the colour detector and consumed by the game logic
    localparam logic [1:0] COLOR_NONE  = 2'b00;
    localparam logic [1:0] COLOR_RED   = 2'b01;
    localparam logic [1:0] COLOR_GREEN = 2'b10;
    localparam logic [1:0] COLOR_BLUE  = 2'b11;

    // Encoding is exported on fsm_state, so the values are fixed
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_CLEAR = 3'd1,
        ST_WAIT_ROLL  = 3'd2,
        ST_MOVING     = 3'd3,
        ST_CHECK_WIN  = 3'd4,
        ST_SWITCH     = 3'd5,
        ST_GAME_OVER  = 3'd6
    } game_state_t;

    // Step count for a detected colour; NONE maps to zero squares
    function automatic int unsigned color_to_steps(
        input logic [1:0]  color,
        input int unsigned steps_red,
        input int unsigned steps_green,
        input int unsigned steps_blue
    );
        int unsigned steps;
        case (color)
            COLOR_RED:   steps = steps_red;
            COLOR_GREEN: steps = steps_green;
            COLOR_BLUE:  steps = steps_blue;
            default:     steps = 0;
        endcase
        return steps;
    endfunction

    // Largest of three step counts, used to size the steps-remaining register
    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/dice_turn_fsm_move_ticker.sv
// Animation-rate divider: counts MOVE_TICKS cycles while enabled and flags the last one.
// Latency: tick is high on the MOVE_TICKS-th enabled cycle after a clear (combinational from the count).
// Backpressure: none; clr has priority over en and holds the count at zero.
module move_ticker #(
    parameter int MOVE_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W    = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise wrap to zero after the last cycle of a period
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && at_last;

endmodule

// File: rtl/dice_turn_fsm.sv
// Two-player dice race: turns each detected die colour into token steps, one square per animation tick.
// Latency: all outputs registered; first square moves MOVE_TICKS cycles after a roll is accepted.
// Backpressure: rolls are only accepted in WAIT_ROLL; a white board must be seen before each roll.
module dice_turn_fsm
    import dice_game_pkg::*;
#(
    parameter  int BOARD_LEN   = 20,
    parameter  int STEPS_RED   = 1,
    parameter  int STEPS_GREEN = 2,
    parameter  int STEPS_BLUE  = 3,
    parameter  int MOVE_TICKS  = 25_000_000,
    localparam int POS_W       = $clog2(BOARD_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       stable_color,
    input  logic             result_ready,
    input  logic             current_state_white,
    input  logic             start_btn,
    output logic [POS_W-1:0] p0_pos,
    output logic [POS_W-1:0] p1_pos,
    output logic             cur_player,
    output logic [2:0]       fsm_state,
    output logic             move_done,
    output logic             winner_valid,
    output logic             winner_id
);

    localparam int unsigned      STEP_MAX = max3(STEPS_RED, STEPS_GREEN, STEPS_BLUE);
    localparam int               STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX + 1) : 1;
    localparam logic [POS_W-1:0] GOAL     = POS_W'(BOARD_LEN - 1);

    game_state_t       state_q, state_d;
    logic [POS_W-1:0]  p0_pos_q, p0_pos_d;
    logic [POS_W-1:0]  p1_pos_q, p1_pos_d;
    logic              cur_player_q, cur_player_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic              move_done_q, move_done_d;
    logic              winner_valid_q, winner_valid_d;
    logic              winner_id_q, winner_id_d;

    logic              tick;
    logic              ticker_clr;
    logic              ticker_en;
    logic              roll_ok;
    logic              new_game;
    logic [POS_W-1:0]  mover_pos;
    logic              mover_at_goal;
    logic [POS_W-1:0]  mover_next_pos;
    logic              last_step;

    // A roll counts only with a real colour; NONE results are dropped
    assign roll_ok  = result_ready && (stable_color != COLOR_NONE);
    assign new_game = start_btn && ((state_q == ST_IDLE) || (state_q == ST_GAME_OVER));

    // Position of the player currently moving, and its clamped successor
    assign mover_pos      = cur_player_q ? p1_pos_q : p0_pos_q;
    assign mover_at_goal  = (mover_pos == GOAL);
    assign mover_next_pos = mover_at_goal ? mover_pos : mover_pos + POS_W'(1);

    // The movement ends when this tick uses the last step or lands on the goal square
    assign last_step = (steps_left_q <= STEP_W'(1)) || (mover_next_pos == GOAL);

    assign ticker_en = (state_q == ST_MOVING);

    move_ticker #(
        .MOVE_TICKS (MOVE_TICKS)
    ) u_move_ticker (
        .clk   (clk),
        .reset (reset),
        .clr   (ticker_clr),
        .en    (ticker_en),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the turn sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_btn) state_d = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                if (current_state_white) state_d = ST_WAIT_ROLL;
            end
            ST_WAIT_ROLL: begin
                if (roll_ok) state_d = ST_MOVING;
            end
            ST_MOVING: begin
                if (tick && last_step) state_d = ST_CHECK_WIN;
            end
            ST_CHECK_WIN: begin
                state_d = mover_at_goal ? ST_GAME_OVER : ST_SWITCH;
            end
            ST_SWITCH: begin
                state_d = ST_WAIT_CLEAR;
            end
            ST_GAME_OVER: begin
                if (start_btn) state_d = ST_WAIT_CLEAR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values, driven by the current state
    always_comb begin
        p0_pos_d       = p0_pos_q;
        p1_pos_d       = p1_pos_q;
        cur_player_d   = cur_player_q;
        steps_left_d   = steps_left_q;
        winner_id_d    = winner_id_q;
        ticker_clr     = 1'b0;
        move_done_d    = (state_d == ST_CHECK_WIN);
        winner_valid_d = (state_d == ST_GAME_OVER);

        if (new_game) begin
            p0_pos_d     = '0;
            p1_pos_d     = '0;
            cur_player_d = 1'b0;
            steps_left_d = '0;
            winner_id_d  = 1'b0;
        end

        case (state_q)
            ST_WAIT_ROLL: begin
                if (roll_ok) begin
                    steps_left_d = STEP_W'(color_to_steps(stable_color, STEPS_RED,
                                                          STEPS_GREEN, STEPS_BLUE));
                    ticker_clr   = 1'b1;
                end
            end
            ST_MOVING: begin
                if (tick) begin
                    if (cur_player_q) begin
                        p1_pos_d = mover_next_pos;
                    end else begin
                        p0_pos_d = mover_next_pos;
                    end
                    // Steps left over after reaching the goal are discarded
                    steps_left_d = last_step ? '0 : steps_left_q - STEP_W'(1);
                end
            end
            ST_CHECK_WIN: begin
                if (mover_at_goal) winner_id_d = cur_player_q;
            end
            ST_SWITCH: begin
                cur_player_d = ~cur_player_q;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers; reset drops any movement in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            p0_pos_q       <= '0;
            p1_pos_q       <= '0;
            cur_player_q   <= 1'b0;
            steps_left_q   <= '0;
            move_done_q    <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_id_q    <= 1'b0;
        end else begin
            p0_pos_q       <= p0_pos_d;
            p1_pos_q       <= p1_pos_d;
            cur_player_q   <= cur_player_d;
            steps_left_q   <= steps_left_d;
            move_done_q    <= move_done_d;
            winner_valid_q <= winner_valid_d;
            winner_id_q    <= winner_id_d;
        end
    end

    assign p0_pos       = p0_pos_q;
    assign p1_pos       = p1_pos_q;
    assign cur_player   = cur_player_q;
    assign fsm_state    = state_q;
    assign move_done    = move_done_q;
    assign winner_valid = winner_valid_q;
    assign winner_id    = winner_id_q;

endmodule

// File: tb/tb_dice_turn_fsm.sv
// Bench for dice_turn_fsm: directed turns plus randomized games against a board-level game model.
// Latency: expected move_done results are queued at roll time and checked when the DUT pulses move_done.
// Backpressure: not applicable; every wait on the DUT is bounded.
module tb_dice_turn_fsm;

    localparam int BL = 8;
    localparam int MT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] stable_color;
    logic       result_ready;
    logic       current_state_white;
    logic       start_btn;
    logic [2:0] p0_pos;
    logic [2:0] p1_pos;
    logic       cur_player;
    logic [2:0] fsm_state;
    logic       move_done;
    logic       winner_valid;
    logic       winner_id;

    dice_turn_fsm #(
        .BOARD_LEN   (BL),
        .STEPS_RED   (1),
        .STEPS_GREEN (2),
        .STEPS_BLUE  (3),
        .MOVE_TICKS  (MT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .stable_color        (stable_color),
        .result_ready        (result_ready),
        .current_state_white (current_state_white),
        .start_btn           (start_btn),
        .p0_pos              (p0_pos),
        .p1_pos              (p1_pos),
        .cur_player          (cur_player),
        .fsm_state           (fsm_state),
        .move_done           (move_done),
        .winner_valid        (winner_valid),
        .winner_id           (winner_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p0;
        int p1;
        int mover;
        bit win;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failed = 0;

    // Game model: token squares, whose turn, whether someone has won
    int mpos[2];
    int mcur;
    bit mover_flag;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_new_game();
        mpos[0] = 0;
        mpos[1] = 0;
        mcur = 0;
        mover_flag = 0;
    endtask

    // Apply one accepted roll to the model and queue the result move_done must show
    task automatic model_roll(input int c);
        int   steps;
        int   np;
        exp_t e;
        case (c)
            1: steps = 1;
            2: steps = 2;
            3: steps = 3;
            default: steps = 0;
        endcase
        np = mpos[mcur] + steps;
        if (np > BL - 1) np = BL - 1;
        mpos[mcur] = np;
        e.p0 = mpos[0];
        e.p1 = mpos[1];
        e.mover = mcur;
        e.win = (np == BL - 1);
        sb.push_back(e);
        if (e.win) mover_flag = 1;
        else mcur = 1 - mcur;
    endtask

    // Monitor: every move_done pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (move_done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("move_done_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_p0_pos", p0_pos, e.p0);
                    check("done_p1_pos", p1_pos, e.p1);
                    check("done_cur_player", cur_player, e.mover);
                    check("done_state", fsm_state, 4);
                    @(negedge clk);
                    check("done_one_cycle", move_done, 0);
                    check("after_done_state", fsm_state, e.win ? 6 : 5);
                    check("after_done_winner_valid", winner_valid, e.win ? 1 : 0);
                    if (e.win) check("after_done_winner_id", winner_id, e.mover);
                end
            end
        end
    end

    // Inputs are driven at the falling edge, away from the sampling edge
    task automatic roll(input int c);
        stable_color = 2'(c);
        result_ready = 1'b1;
        if (c != 0) model_roll(c);
        @(negedge clk);
        result_ready = 1'b0;
        stable_color = 2'b00;
    endtask

    task automatic go_roll_ready();
        current_state_white = 1'b1;
        @(negedge clk);
        current_state_white = 1'b0;
        check("enter_wait_roll", fsm_state, 2);
    endtask

    task automatic wait_turn_end();
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fsm_state == 3'd1 || fsm_state == 3'd6) begin
                done = 1;
                break;
            end
        end
        check("turn_end_timeout", done, 1);
        check("turn_end_state", fsm_state, mover_flag ? 6 : 1);
        if (!mover_flag) check("turn_end_cur_player", cur_player, mcur);
    endtask

    task automatic play_turn(input int c);
        if ($urandom_range(0, 1) == 1) begin
            stable_color = 2'($urandom_range(0, 3));
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            check("wait_clear_ignores_roll", fsm_state, 1);
        end
        go_roll_ready();
        if ($urandom_range(0, 3) == 0) begin
            roll(0);
            check("none_roll_ignored", fsm_state, 2);
        end
        roll(c);
        wait_turn_end();
    endtask

    task automatic start_game();
        start_btn = 1'b1;
        model_new_game();
        @(negedge clk);
        start_btn = 1'b0;
        check("start_state", fsm_state, 1);
        check("start_p0", p0_pos, 0);
        check("start_p1", p1_pos, 0);
        check("start_cur", cur_player, 0);
        check("start_winner_valid", winner_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        stable_color = 2'b00;
        result_ready = 1'b0;
        current_state_white = 1'b0;
        start_btn = 1'b0;
        model_new_game();
        repeat (3) @(negedge clk);
        check("rst_state", fsm_state, 0);
        check("rst_p0", p0_pos, 0);
        check("rst_p1", p1_pos, 0);
        check("rst_cur", cur_player, 0);
        check("rst_move_done", move_done, 0);
        check("rst_winner_valid", winner_valid, 0);
        check("rst_winner_id", winner_id, 0);
        reset = 1'b0;

        // IDLE ignores everything but start_btn
        current_state_white = 1'b1;
        result_ready = 1'b1;
        stable_color = 2'b11;
        @(negedge clk);
        result_ready = 1'b0;
        check("idle_ignores_inputs", fsm_state, 0);

        // Start with white already present: WAIT_CLEAR then WAIT_ROLL
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        check("start_to_wait_clear", fsm_state, 1);
        @(negedge clk);
        current_state_white = 1'b0;
        check("white_to_wait_roll", fsm_state, 2);
        check("start_positions", p0_pos + p1_pos, 0);

        // Player 0 rolls BLUE: one square every MT cycles
        roll(3);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 3)  check("blue_p0_k3", p0_pos, 0);
            if (k == 4)  check("blue_p0_k4", p0_pos, 1);
            if (k == 7)  check("blue_p0_k7", p0_pos, 1);
            if (k == 8)  check("blue_p0_k8", p0_pos, 2);
            if (k == 11) check("blue_p0_k11", p0_pos, 2);
            if (k == 12) check("blue_p0_k12", p0_pos, 3);
            if (k == 13) check("blue_switch_state", fsm_state, 5);
            if (k == 14) begin
                check("blue_next_state", fsm_state, 1);
                check("blue_next_player", cur_player, 1);
            end
        end

        // Rolls during WAIT_CLEAR with no white board are ignored
        for (int i = 0; i < 3; i++) begin
            result_ready = 1'b1;
            stable_color = 2'b11;
            @(negedge clk);
            result_ready = 1'b0;
            check("clear_ignore_state", fsm_state, 1);
        end
        check("clear_ignore_p0", p0_pos, 3);
        check("clear_ignore_p1", p1_pos, 0);

        // Roll in the same cycle as the WAIT_CLEAR exit is not accepted
        current_state_white = 1'b1;
        result_ready = 1'b1;
        stable_color = 2'b11;
        @(negedge clk);
        current_state_white = 1'b0;
        result_ready = 1'b0;
        check("simul_roll_state", fsm_state, 2);
        @(negedge clk);
        check("simul_roll_hold", fsm_state, 2);

        // NONE result in WAIT_ROLL is dropped
        roll(0);
        check("none_state", fsm_state, 2);
        @(negedge clk);
        check("none_hold", fsm_state, 2);

        roll(3);
        wait_turn_end();
        play_turn(1);
        play_turn(3);
        play_turn(1);
        check("pre_win_p1", p1_pos, 6);
        check("pre_win_p0", p0_pos, 5);

        // Player 1 at square 6 rolls GREEN: one step to the goal, second step discarded
        go_roll_ready();
        roll(2);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) check("win_p1_k3", p1_pos, 6);
            if (k == 4) begin
                check("win_p1_k4", p1_pos, 7);
                check("win_check_state", fsm_state, 4);
            end
            if (k == 5) begin
                check("win_state", fsm_state, 6);
                check("win_valid", winner_valid, 1);
                check("win_id", winner_id, 1);
            end
        end

        // GAME_OVER holds positions and ignores rolls
        current_state_white = 1'b1;
        result_ready = 1'b1;
        stable_color = 2'b01;
        @(negedge clk);
        current_state_white = 1'b0;
        result_ready = 1'b0;
        check("over_hold_state", fsm_state, 6);
        check("over_hold_p1", p1_pos, 7);
        check("over_hold_p0", p0_pos, 5);

        start_game();

        // Reset during movement: p0 at square 2 with one step left
        go_roll_ready();
        roll(3);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 8) check("midmove_p0", p0_pos, 2);
        end
        reset = 1'b1;
        sb.delete();
        model_new_game();
        @(negedge clk);
        reset = 1'b0;
        check("midrst_state", fsm_state, 0);
        check("midrst_p0", p0_pos, 0);
        check("midrst_p1", p1_pos, 0);
        check("midrst_move_done", move_done, 0);
        check("midrst_cur", cur_player, 0);
        repeat (MT * 4) @(negedge clk);
        check("midrst_stays_idle", fsm_state, 0);

        // Randomized full games against the model
        for (int g = 0; g < 4; g++) begin
            start_game();
            for (int t = 0; t < 40 && !mover_flag; t++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                play_turn($urandom_range(1, 3));
            end
            check("random_game_finished", mover_flag, 1);
            check("random_winner_id", winner_id, 1 - mcur == 0 ? 1 : mcur);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dice_turn_fsm.md
Name: dice_turn_fsm

Overview:
- Game-logic stage directly downstream of the colour detector; consumes `stable_color`, `result_ready` and `current_state_white`.
- Runs a two-player dice race: each detected die colour becomes a step count.
- The current player's token advances one square per animation tick, then the turn passes to the other player.
- A white background must be seen between rolls so one die placement cannot be counted twice. Outputs drive the VGA board overlay and status LEDs.

Parameters:
- BOARD_LEN, 20, number of squares; positions 0..BOARD_LEN-1; last square is the goal
- POS_W, $clog2(BOARD_LEN), position width (derived, localparam-style)
- STEPS_RED, 1, squares moved for RED (2'b01)
- STEPS_GREEN, 2, squares moved for GREEN (2'b10)
- STEPS_BLUE, 3, squares moved for BLUE (2'b11)
- MOVE_TICKS, 25_000_000, clk cycles per single-square move (animation rate); must be >= 1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stable_color  in  2  00=NONE, 01=RED, 10=GREEN, 11=BLUE
- result_ready  in  1  one-cycle pulse: stable_color is valid
- current_state_white  in  1  level: white background (no die) detected
- start_btn  in  1  debounced one-cycle pulse: start or restart the game
- p0_pos  out  POS_W  player 0 square
- p1_pos  out  POS_W  player 1 square
- cur_player  out  1  player whose turn it is
- fsm_state  out  3  encoded state for display/debug
- move_done  out  1  one-cycle pulse when a turn's movement finishes
- winner_valid  out  1  level, high in GAME_OVER
- winner_id  out  1  winning player; valid when winner_valid=1

Behaviour:
- Reset, synchronous, wins over all inputs:
  - state=IDLE; p0_pos=p1_pos=0; cur_player=0.
  - move_done=0, winner_valid=0, winner_id=0; tick counter=0; steps_left=0.
  - Reset mid-MOVING discards the remaining steps.
- States and encodings: IDLE(0), WAIT_CLEAR(1), WAIT_ROLL(2), MOVING(3), CHECK_WIN(4), SWITCH(5), GAME_OVER(6).
- IDLE:
  - On start_btn: positions=0, cur_player=0, go to WAIT_CLEAR.
  - All other inputs are ignored.
- WAIT_CLEAR: when current_state_white=1, go to WAIT_ROLL next cycle. result_ready is ignored here.
- WAIT_ROLL:
  - result_ready=1 with stable_color!=00: load steps_left from the colour map, clear the tick counter, go to MOVING.
  - result_ready with NONE: ignored, stay.
- MOVING:
  - Tick counter runs 0..MOVE_TICKS-1.
  - On the cycle where counter==MOVE_TICKS-1:
    - cur_player's position +1;
    - steps_left -1;
    - counter -> 0.
  - First square moves MOVE_TICKS cycles after entry.
  - Leave for CHECK_WIN on the same tick where steps_left becomes 0 or the position reaches BOARD_LEN-1. Overshoot is clamped; an exact finish is not required.
- CHECK_WIN (1 cycle):
  - Assert move_done.
  - If the mover's position == BOARD_LEN-1: winner_id=cur_player, go to GAME_OVER. Otherwise go to SWITCH.
- SWITCH (1 cycle): toggle cur_player, go to WAIT_CLEAR.
- GAME_OVER:
  - winner_valid=1; positions hold.
  - start_btn behaves as in IDLE (new game, winner_valid cleared).
- start_btn outside IDLE/GAME_OVER is ignored.
- Simultaneous events: result_ready arriving in the same cycle as the WAIT_CLEAR->WAIT_ROLL transition is ignored. A roll is only accepted while already in WAIT_ROLL.
- Output timing: all outputs are registered. move_done is high exactly 1 cycle per turn.
- Position arithmetic is POS_W-bit unsigned and never wraps: the increment is blocked at BOARD_LEN-1.

Decomposition:
- Shared package dice_game_pkg:
  - colour codes COLOR_NONE/RED/GREEN/BLUE (2-bit), also used by the colour detector;
  - state enum game_state_t;
  - a function mapping colour to step count.
- Sub-module move_ticker:
  - MOVE_TICKS counter with clear/enable inputs and a one-cycle tick output;
  - instantiated once and reusable for display blinking.
- The FSM and position registers stay in dice_turn_fsm.

Test Plan (BOARD_LEN=8, MOVE_TICKS=4):
- Reset, then start_btn, white=1 -> state 1 then 2 within 2 cycles; positions 0, cur_player 0.
- In WAIT_ROLL, result_ready with BLUE:
  - p0_pos goes 1,2,3 at +4, +8, +12 cycles;
  - then a move_done pulse; cur_player=1; state=1.
- In WAIT_ROLL, result_ready with NONE -> no state change. Repeated result_ready while in WAIT_CLEAR (white=0) -> ignored, positions unchanged.
- Win with overshoot: p1_pos=6, roll GREEN -> p1_pos=7 after 1 tick; the second step is discarded. Then winner_valid=1, winner_id=1, state=6.
- Reset asserted mid-MOVING (p0 at 2, 1 step left) -> next cycle all positions 0, state IDLE, no move_done.
- From GAME_OVER, start_btn -> winner_valid=0, positions 0, cur_player 0, state WAIT_CLEAR.
